// File: rtl/count_frame_framer.sv
// Frame delimiter behind the counter/metadata aligner: adds tlast, checks count continuity,
// and, when COUNT_FRAME_HEADER_EN is defined, puts a sequence-number header ahead of each frame.
module count_frame_framer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_final_cnt,
  input  logic [15:0]           s_axis_count,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [15:0]           frame_seq,
  output logic                  count_err
);

  typedef enum logic {SOF, BODY} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  state_t      state, state_nx;
  entry_t      q [2];
  entry_t      q_nx [2];
  logic [1:0]  cnt, cnt_r, cnt_nx;
  logic [15:0] expected;
  logic        acc, rd, ready_nx;

  assign acc           = s_axis_tvalid & s_axis_tready;
  assign m_axis_tvalid = (cnt != 2'd0);
  assign rd            = m_axis_tvalid & m_axis_tready;
  assign m_axis_tdata  = q[0].data;
  assign m_axis_tlast  = q[0].last;

`ifdef COUNT_FRAME_HEADER_EN
  logic [DATA_WIDTH-1:0] hdr_word;

  always_comb begin
    hdr_word       = '0;
    hdr_word[31:0] = {16'hA5C3, frame_seq};
  end
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) state <= SOF;
    else            state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    if (acc) state_nx = s_axis_final_cnt ? SOF : BODY;
  end

  // FSM: outputs. A header frame start needs both entries, so SOF waits for an empty queue.
  always_comb begin
    ready_nx = (cnt_nx != 2'd2);
`ifdef COUNT_FRAME_HEADER_EN
    if (state_nx == SOF) ready_nx = (cnt_nx == 2'd0);
`endif
  end

  // Queue update: pop the head first, then append behind whatever remains.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    q_nx  = q;
    cnt_r = cnt;
    if (rd) begin
      q_nx[0] = q[1];
      cnt_r   = cnt - 2'd1;
    end
    cnt_nx = cnt_r;
    if (acc) begin
`ifdef COUNT_FRAME_HEADER_EN
      if (state == SOF) begin
        q_nx[0] = '{data: hdr_word, last: 1'b0};
        q_nx[1] = '{data: s_axis_tdata, last: s_axis_final_cnt};
        cnt_nx  = 2'd2;
      end else
`endif
      begin
        q_nx[cnt_r[0]] = '{data: s_axis_tdata, last: s_axis_final_cnt};
        cnt_nx         = cnt_r + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      // NOTE: the two queue entries are reset because the head drives m_axis_tdata directly.
      q[0]          <= '0;
      q[1]          <= '0;
      cnt           <= 2'd0;
      s_axis_tready <= 1'b0;
    end else begin
      q[0]          <= q_nx[0];
      q[1]          <= q_nx[1];
      cnt           <= cnt_nx;
      s_axis_tready <= ready_nx;
    end
  end

  // Sequence numbering and count continuity; a bad beat still passes and resyncs the check.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      frame_seq <= 16'd0;
      expected  <= 16'd0;
      count_err <= 1'b0;
    end else if (acc) begin
      if (s_axis_final_cnt) frame_seq <= frame_seq + 16'd1;
      expected <= s_axis_final_cnt ? 16'd0 : s_axis_count + 16'd1;
      if (s_axis_count != expected) count_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_count_frame_framer.sv
// Directed self-checking bench for count_frame_framer; header expectations follow
// COUNT_FRAME_HEADER_EN so the same bench serves both builds.
module tb_count_frame_framer;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic          s_axis_tvalid;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_final_cnt;
  logic [15:0]   s_axis_count;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [15:0]   frame_seq;
  logic          count_err;

  always #5 clk = ~clk;

  count_frame_framer #(.DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .sync_reset       (sync_reset),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_final_cnt (s_axis_final_cnt),
    .s_axis_count     (s_axis_count),
    .s_axis_tready    (s_axis_tready),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tready    (m_axis_tready),
    .frame_seq        (frame_seq),
    .count_err        (count_err)
  );

  int checks = 0;
  int errors = 0;

  logic [DW:0] exp_q[$];
  logic [DW:0] obs_q[$];
  bit          capture = 1'b1;
  int          bulk_beats = 0;
  int          bulk_lasts = 0;
  bit          saw_stall = 1'b0;
  bit          toggling = 1'b0;
  logic [DW:0] head;

  // Transfers complete at the next posedge; inputs only change 1 time unit after a posedge.
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      if (capture) obs_q.push_back({m_axis_tlast, m_axis_tdata});
      else begin
        bulk_beats++;
        if (m_axis_tlast) bulk_lasts++;
      end
    end
    if (s_axis_tvalid && !s_axis_tready) saw_stall = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW:0] hdr(input logic [15:0] seq);
    logic [DW:0] w;
    w       = '0;
    w[31:0] = {16'hA5C3, seq};
    return w;
  endfunction

  task automatic push_hdr(input logic [15:0] seq);
`ifdef COUNT_FRAME_HEADER_EN
    exp_q.push_back(hdr(seq));
`else
    if (seq == 16'hFFFF) exp_q.push_back('0); // unreachable seq value in this bench
`endif
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [15:0] c, input logic fin);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    s_axis_count = c;
    s_axis_final_cnt = fin;
    if (capture) exp_q.push_back({fin, d});
    while (!done) begin
      @(negedge clk);
      if (s_axis_tready) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        checks++;
        errors++;
        $error("FAIL send_timeout: observed=no_accept expected=accept count=%0h", c);
        done = 1'b1;
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain();
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    sync_reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_count = '0;
    s_axis_final_cnt = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_frame_seq", 64'(frame_seq), 64'd0);
    check("rst_count_err", 64'(count_err), 64'd0);
    sync_reset = 1'b0;
    @(posedge clk);
    #1;
    check("tready_after_reset", 64'(s_axis_tready), 64'd1);
    m_axis_tready = 1'b1;

    // Four-beat frame, counts 0..3
    push_hdr(16'd0);
    for (int i = 0; i < 4; i++) send(32'h1000_0000 + DW'(i), 16'(i), i == 3);
    drain();
    compare("frame4");
    check("frame4_seq", 64'(frame_seq), 64'd1);
    check("frame4_cerr", 64'(count_err), 64'd0);

    // Two single-beat frames
    push_hdr(16'd1);
    send(32'h2000_0000, 16'd0, 1'b1);
    push_hdr(16'd2);
    send(32'h2000_0001, 16'd0, 1'b1);
    drain();
    compare("single");
    check("single_seq", 64'(frame_seq), 64'd3);

    // Count gap 0,1,3,4
    push_hdr(16'd3);
    send(32'h3000_0000, 16'd0, 1'b0);
    send(32'h3000_0001, 16'd1, 1'b0);
    check("gap_cerr_before", 64'(count_err), 64'd0);
    send(32'h3000_0002, 16'd3, 1'b0);
    check("gap_cerr_set", 64'(count_err), 64'd1);
    send(32'h3000_0003, 16'd4, 1'b1);
    check("gap_cerr_sticky", 64'(count_err), 64'd1);
    drain();
    compare("gap");
    check("gap_seq", 64'(frame_seq), 64'd4);

    // 64-beat frame with m_axis_tready toggling every cycle
    saw_stall = 1'b0;
    toggling = 1'b1;
    push_hdr(16'd4);
    fork
      begin
        for (int i = 0; i < 64; i++) send(32'h4000_0000 + DW'(i), 16'(i), i == 63);
        toggling = 1'b0;
      end
      begin
        while (toggling) begin
          @(posedge clk);
          #1;
          m_axis_tready = ~m_axis_tready;
        end
      end
    join
    m_axis_tready = 1'b1;
    drain();
    compare("toggle");
    check("toggle_stall_seen", 64'(saw_stall), 64'd1);
    check("toggle_seq", 64'(frame_seq), 64'd5);

    // Fill the queue with the sink stalled, then reset mid-frame
    m_axis_tready = 1'b0;
`ifdef COUNT_FRAME_HEADER_EN
    send(32'h5000_0000, 16'd0, 1'b0);
    head = hdr(16'd5);
`else
    send(32'h5000_0000, 16'd0, 1'b0);
    send(32'h5000_0001, 16'd1, 1'b0);
    head = {1'b0, 32'h5000_0000};
`endif
    @(posedge clk);
    #1;
    check("full_s_tready", 64'(s_axis_tready), 64'd0);
    check("full_m_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("full_head", 64'({m_axis_tlast, m_axis_tdata}), 64'(head));
    repeat (3) @(posedge clk);
    #1;
    check("full_head_stable", 64'({m_axis_tlast, m_axis_tdata}), 64'(head));
    obs_q.delete();
    exp_q.delete();
    sync_reset = 1'b1;
    #1;
    check("mid_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("mid_rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    check("mid_rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    check("mid_rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("mid_rst_frame_seq", 64'(frame_seq), 64'd0);
    check("mid_rst_count_err", 64'(count_err), 64'd0);
    @(posedge clk);
    #1;
    sync_reset = 1'b0;
    m_axis_tready = 1'b1;
    push_hdr(16'd0);
    send(32'h6000_0000, 16'd0, 1'b1);
    drain();
    compare("post_reset");
    check("post_reset_seq", 64'(frame_seq), 64'd1);
    check("post_reset_cerr", 64'(count_err), 64'd0);

    // Full 16-bit count run ending with 0xFFFE, 0xFFFF(final)
    capture = 1'b0;
    bulk_beats = 0;
    bulk_lasts = 0;
    for (int i = 0; i < 65536; i++) send(DW'(i), 16'(i), i == 65535);
    drain();
    capture = 1'b1;
    check("wrap_cerr", 64'(count_err), 64'd0);
    check("wrap_lasts", 64'(bulk_lasts), 64'd1);
`ifdef COUNT_FRAME_HEADER_EN
    check("wrap_beats", 64'(bulk_beats), 64'd65537);
`else
    check("wrap_beats", 64'(bulk_beats), 64'd65536);
`endif
    check("wrap_seq", 64'(frame_seq), 64'd2);
    push_hdr(16'd2);
    send(32'h7000_0000, 16'd0, 1'b1);
    drain();
    compare("after_wrap");
    check("after_wrap_cerr", 64'(count_err), 64'd0);
    check("after_wrap_seq", 64'(frame_seq), 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
